// File: rtl/microseq_pkg.sv
// Shared definitions for the microcode sequencer and its helpers.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package microseq_pkg;

    // Sequencer opcode lives in the top OP_W bits of every microword.
    localparam int OP_W = 3;

    // Conditional-jump control bits sit just above the target address:
    // bit UADDR_W+JMPC_SEL_OFS picks carry (1) or zero (0),
    // bit UADDR_W+JMPC_VAL_OFS is the flag value that makes the jump taken.
    localparam int JMPC_SEL_OFS = 1;
    localparam int JMPC_VAL_OFS = 0;

    typedef enum logic [OP_W-1:0] {
        OP_EXEC = 3'b000,
        OP_HALT = 3'b011,
        OP_JMP  = 3'b100,
        OP_JMPC = 3'b101,
        OP_CALL = 3'b110,
        OP_RET  = 3'b111
    } useq_op_e;

    // Width helper that never returns zero, so 1-entry configurations
    // still get a usable 1-bit field.
    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Every code that is not a sequencer op is an ordinary microword.
    function automatic useq_op_e decode_op(input logic [OP_W-1:0] code);
        case (code)
            3'b011:  return OP_HALT;
            3'b100:  return OP_JMP;
            3'b101:  return OP_JMPC;
            3'b110:  return OP_CALL;
            3'b111:  return OP_RET;
            default: return OP_EXEC;
        endcase
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: highest set request index wins.
// Latency: purely combinational.
// Backpressure: none; output follows input in the same cycle.
module irq_prio_enc
    import microseq_pkg::*;
#(
    parameter int NUM_IRQ = 15,
    localparam int IDX_W = clog2_safe(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/microseq_gen.sv
// Microcode sequencer: steps an external sync ROM, resolves jump/call/ret/halt, issues microwords.
// Latency: one microword resolves per step_en; an issued word appears with uword_valid one clk after its step.
// Backpressure: none; caller paces with step_en (>=1 idle clk between strobes). Call stack enabled by MICROSEQ_STACK_EN.
module microseq_gen
    import microseq_pkg::*;
#(
    parameter int UADDR_W     = 9,
    parameter int UWORD_W     = 16,
    parameter int NUM_IRQ     = 15,
    parameter int MAX_STEPS   = 12,
    parameter int STACK_DEPTH = 4,
    parameter int IRQ_UADDR   = 400,
    parameter int IRQ_STEPS   = 12,
    localparam int SW = clog2_safe(MAX_STEPS + 1),
    localparam int IW = clog2_safe(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    input  logic [UADDR_W-1:0] start_uaddr,
    input  logic [SW-1:0]      cycle_steps,
    input  logic               zero,
    input  logic               carry,
    input  logic               irq_enable,
    input  logic               irq_block,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [UADDR_W-1:0] rom_addr,
    input  logic [UWORD_W-1:0] rom_data,
    output logic [UWORD_W-1:0] uword,
    output logic               uword_valid,
    output logic [SW-1:0]      stage,
    output logic               last_step,
    output logic               performing_irq,
    output logic [IW-1:0]      irq_vector,
    output logic               halted,
    output logic               stack_err,
    output logic               ss_ready
);

    if (STACK_DEPTH < 1) begin : g_cfg_check
        $error("microseq_gen: STACK_DEPTH must be at least 1");
    end

    logic [SW-1:0]      stage_q, stage_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic [UWORD_W-1:0] uword_q, uword_d;
    logic               uword_valid_q, uword_valid_d;
    logic               perf_q, perf_d;
    logic [IW-1:0]      vec_q, vec_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic               pending_q, pending_d;

`ifdef MICROSEQ_STACK_EN
    localparam int PW = clog2_safe(STACK_DEPTH + 1);
    logic [PW-1:0]                           sp_q, sp_d;
    logic [STACK_DEPTH-1:0][UADDR_W-1:0]     stack_q, stack_d;
    logic [UADDR_W-1:0]                      stack_top;
`endif

    logic               irq_any;
    logic [IW-1:0]      irq_idx;
    logic               eligible;
    logic               decode_step;
    logic               exec_step;
    logic               take_irq;
    logic [SW-1:0]      active_len;
    logic [UADDR_W-1:0] upc_inc;
    logic [UADDR_W-1:0] jmp_tgt;
    logic               jmpc_flag;
    useq_op_e           op;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req (irq_req & irq_mask),
        .any (irq_any),
        .idx (irq_idx)
    );

    // A request only counts when the CPU would accept it and no service is already running.
    assign eligible    = irq_any & irq_enable & ~irq_block & ~perf_q;
    assign decode_step = step_en && (stage_q == '0);
    assign exec_step   = step_en && (stage_q != '0);
    assign take_irq    = decode_step && (pending_q || eligible);
    assign active_len  = perf_q ? SW'(IRQ_STEPS) : cycle_steps;
    assign last_step   = (stage_q == active_len - SW'(1));
    assign upc_inc     = upc_q + UADDR_W'(1);
    assign jmp_tgt     = rom_data[UADDR_W-1:0];
    assign jmpc_flag   = rom_data[UADDR_W+JMPC_SEL_OFS] ? carry : zero;
    assign op          = decode_op(rom_data[UWORD_W-1 -: OP_W]);

`ifdef MICROSEQ_STACK_EN
    // Entry below the stack pointer is the return address a RET would pop.
    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == PW'(i + 1)) begin
                stack_top = stack_q[i];
            end
        end
    end
`endif

    // Next-state: DECODE picks the entry (interrupt or instruction), later steps resolve one word each.
    always_comb begin
        stage_d       = stage_q;
        upc_d         = upc_q;
        uword_d       = uword_q;
        uword_valid_d = 1'b0;
        perf_d        = perf_q;
        vec_d         = vec_q;
        halted_d      = halted_q;
        err_d         = err_q;
        pending_d     = pending_q;
`ifdef MICROSEQ_STACK_EN
        sp_d          = sp_q;
        stack_d       = stack_q;
`endif

        // Latch is consumed by DECODE; while servicing, eligible is low so a
        // held request re-latches only after performing_irq drops.
        if (take_irq) begin
            pending_d = 1'b0;
        end else if (eligible) begin
            pending_d = 1'b1;
        end

        if (decode_step) begin
`ifdef MICROSEQ_STACK_EN
            sp_d = '0;
`endif
            if (take_irq) begin
                perf_d   = 1'b1;
                halted_d = 1'b0;
                vec_d    = irq_idx;
                upc_d    = UADDR_W'(IRQ_UADDR);
                stage_d  = (IRQ_STEPS > 1) ? SW'(1) : '0;
            end else begin
                perf_d = 1'b0;
                // A halted core sits in DECODE until an interrupt wakes it.
                if (!halted_q) begin
                    upc_d   = start_uaddr;
                    stage_d = last_step ? '0 : SW'(1);
                end
            end
        end else if (exec_step) begin
            if (last_step) begin
                stage_d = '0;
                perf_d  = 1'b0;
            end else begin
                stage_d = stage_q + SW'(1);
            end

            case (op)
                OP_JMP: begin
                    upc_d = jmp_tgt;
                end
                OP_JMPC: begin
                    upc_d = (jmpc_flag == rom_data[UADDR_W+JMPC_VAL_OFS]) ? jmp_tgt : upc_inc;
                end
                OP_CALL: begin
`ifdef MICROSEQ_STACK_EN
                    // A full stack drops the return address but the jump still happens.
                    if (sp_q == PW'(STACK_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (sp_q == PW'(i)) begin
                                stack_d[i] = upc_inc;
                            end
                        end
                        sp_d = sp_q + PW'(1);
                    end
`endif
                    upc_d = jmp_tgt;
                end
                OP_RET: begin
`ifdef MICROSEQ_STACK_EN
                    if (sp_q == '0) begin
                        upc_d = '0;
                        err_d = 1'b1;
                    end else begin
                        sp_d  = sp_q - PW'(1);
                        upc_d = stack_top;
                    end
`else
                    // Without storage a return has nowhere to go: flag it and fall through.
                    err_d = 1'b1;
                    upc_d = upc_inc;
`endif
                end
                OP_HALT: begin
                    // Halting ends the current sequence, including an interrupt service.
                    halted_d = 1'b1;
                    stage_d  = '0;
                    perf_d   = 1'b0;
                end
                default: begin
                    uword_d       = rom_data;
                    uword_valid_d = 1'b1;
                    upc_d         = upc_inc;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q       <= '0;
            upc_q         <= '0;
            uword_q       <= '0;
            uword_valid_q <= 1'b0;
            perf_q        <= 1'b0;
            vec_q         <= '0;
            halted_q      <= 1'b0;
            err_q         <= 1'b0;
            pending_q     <= 1'b0;
`ifdef MICROSEQ_STACK_EN
            sp_q          <= '0;
`endif
        end else begin
            stage_q       <= stage_d;
            upc_q         <= upc_d;
            uword_q       <= uword_d;
            uword_valid_q <= uword_valid_d;
            perf_q        <= perf_d;
            vec_q         <= vec_d;
            halted_q      <= halted_d;
            err_q         <= err_d;
            pending_q     <= pending_d;
`ifdef MICROSEQ_STACK_EN
            sp_q          <= sp_d;
`endif
        end
    end

`ifdef MICROSEQ_STACK_EN
    // Stack storage needs no reset: entries are only read below a valid pointer.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end
`endif

    assign rom_addr       = upc_q;
    assign uword          = uword_q;
    assign uword_valid    = uword_valid_q;
    assign stage          = stage_q;
    assign performing_irq = perf_q;
    assign irq_vector     = vec_q;
    assign halted         = halted_q;
    assign stack_err      = err_q;
    assign ss_ready       = (stage_q == '0) && !pending_q && !eligible && !irq_block;

endmodule

// File: tb/tb_microseq_gen.sv
// Self-checking bench for microseq_gen: directed scenarios plus randomized program runs.
// Latency: checks every clk, #1 after the rising edge, against a step-level reference model.
// Backpressure: n/a; bench paces step_en with at least one idle clk between strobes.
module tb_microseq_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_en;
    logic [8:0]  start_uaddr;
    logic [3:0]  cycle_steps;
    logic        zero;
    logic        carry;
    logic        irq_enable;
    logic        irq_block;
    logic [14:0] irq_req;
    logic [14:0] irq_mask;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] uword;
    logic        uword_valid;
    logic [3:0]  stage;
    logic        last_step;
    logic        performing_irq;
    logic [3:0]  irq_vector;
    logic        halted;
    logic        stack_err;
    logic        ss_ready;

    logic [15:0] rom [0:511];

    int n_vec = 0;
    int n_bad = 0;
    int n_uv  = 0;

    // Reference model state (plain integers and a queue for the call stack).
    int  m_stage, m_upc, m_uw, m_vec;
    bit  m_uv, m_perf, m_halt, m_err, m_pend;
    int  m_stk[$];

    always #5 clk = ~clk;

    // Synchronous-read ROM: data for an address appears one clk later.
    always @(posedge clk) rom_data <= rom[rom_addr];

    microseq_gen dut (
        .clk            (clk),
        .reset          (reset),
        .step_en        (step_en),
        .start_uaddr    (start_uaddr),
        .cycle_steps    (cycle_steps),
        .zero           (zero),
        .carry          (carry),
        .irq_enable     (irq_enable),
        .irq_block      (irq_block),
        .irq_req        (irq_req),
        .irq_mask       (irq_mask),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .uword          (uword),
        .uword_valid    (uword_valid),
        .stage          (stage),
        .last_step      (last_step),
        .performing_irq (performing_irq),
        .irq_vector     (irq_vector),
        .halted         (halted),
        .stack_err      (stack_err),
        .ss_ready       (ss_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] w_exec(input int v);
        logic [12:0] p;
        p = v[12:0];
        return {3'b001, p};
    endfunction
    function automatic logic [15:0] w_jmp(input int t);
        logic [8:0] a;
        a = t[8:0];
        return {3'b100, 4'b0000, a};
    endfunction
    function automatic logic [15:0] w_jmpc(input bit sel_c, input bit val, input int t);
        logic [8:0] a;
        a = t[8:0];
        return {3'b101, 2'b00, sel_c, val, a};
    endfunction
    function automatic logic [15:0] w_call(input int t);
        logic [8:0] a;
        a = t[8:0];
        return {3'b110, 4'b0000, a};
    endfunction
    function automatic logic [15:0] w_ret();
        return 16'hE000;
    endfunction
    function automatic logic [15:0] w_halt();
        return 16'h6000;
    endfunction

    function automatic int highest(input logic [14:0] v);
        int r = 0;
        for (int i = 0; i < 15; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit m_eligible();
        return ((irq_req & irq_mask) != 15'd0) && irq_enable && !irq_block && !m_perf;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        logic [15:0] w;
        bit elig, flag;
        int len;
        elig = m_eligible();
        m_uv = 1'b0;
        if (reset) begin
            m_stage = 0; m_upc = 0; m_uw = 0; m_vec = 0;
            m_perf = 0; m_halt = 0; m_err = 0; m_pend = 0;
            m_stk.delete();
        end else if (step_en && m_stage == 0) begin
            m_stk.delete();
            if (m_pend || elig) begin
                m_perf = 1; m_halt = 0; m_pend = 0;
                m_vec = highest(irq_req & irq_mask);
                m_upc = 400;
                m_stage = 1;
            end else begin
                m_perf = 0;
                if (!m_halt) begin
                    m_upc = int'(start_uaddr);
                    m_stage = (cycle_steps > 1) ? 1 : 0;
                end
            end
        end else begin
            if (elig) m_pend = 1;
            if (step_en) begin
                w = rom[m_upc];
                len = m_perf ? 12 : int'(cycle_steps);
                if (m_stage + 1 >= len) begin
                    m_stage = 0;
                    m_perf = 0;
                end else begin
                    m_stage++;
                end
                case (w[15:13])
                    3'b100: m_upc = int'(w[8:0]);
                    3'b101: begin
                        flag = w[10] ? carry : zero;
                        m_upc = (flag == w[9]) ? int'(w[8:0]) : (m_upc + 1) % 512;
                    end
                    3'b110: begin
`ifdef MICROSEQ_STACK_EN
                        if (m_stk.size() < 4) m_stk.push_back((m_upc + 1) % 512);
                        else m_err = 1;
`endif
                        m_upc = int'(w[8:0]);
                    end
                    3'b111: begin
`ifdef MICROSEQ_STACK_EN
                        if (m_stk.size() == 0) begin
                            m_upc = 0;
                            m_err = 1;
                        end else begin
                            m_upc = m_stk.pop_back();
                        end
`else
                        m_err = 1;
                        m_upc = (m_upc + 1) % 512;
`endif
                    end
                    3'b011: begin
                        m_halt = 1;
                        m_stage = 0;
                        m_perf = 0;
                    end
                    default: begin
                        m_uw = int'(w);
                        m_uv = 1;
                        m_upc = (m_upc + 1) % 512;
                    end
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        int len;
        len = m_perf ? 12 : int'(cycle_steps);
        chk("stage", stage, m_stage);
        chk("rom_addr", rom_addr, m_upc);
        chk("uword_valid", uword_valid, m_uv);
        chk("uword", uword, m_uw);
        chk("halted", halted, m_halt);
        chk("performing_irq", performing_irq, m_perf);
        chk("irq_vector", irq_vector, m_vec);
        chk("stack_err", stack_err, m_err);
        chk("last_step", last_step, (m_stage == len - 1));
        chk("ss_ready", ss_ready, (m_stage == 0) && !m_pend && !m_eligible() && !irq_block);
    endtask

    task automatic cyc(input logic sen);
        @(negedge clk);
        step_en = sen;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (uword_valid) n_uv++;
    endtask

    task automatic stp();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        cyc(1'b0);
    endtask

    initial begin
        reset = 1'b1; step_en = 1'b0; start_uaddr = '0; cycle_steps = 4'd1;
        zero = 1'b0; carry = 1'b0; irq_enable = 1'b0; irq_block = 1'b0;
        irq_req = '0; irq_mask = 15'h7FFF;
        for (int i = 0; i < 512; i++) rom[i] = w_exec(i);

        cyc(1'b0);
        cyc(1'b0);
        chk("rst_stage", stage, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_uword", uword, 0);
        chk("rst_uword_valid", uword_valid, 0);
        chk("rst_irq_vector", irq_vector, 0);
        reset = 1'b0;
        cyc(1'b0);

        // Linear run through 10..13.
        start_uaddr = 9'd10; cycle_steps = 4'd5;
        n_uv = 0;
        for (int i = 0; i < 4; i++) begin
            stp();
            chk("lin_addr", rom_addr, 10 + i);
        end
        stp();
        chk("lin_pulses", n_uv, 4);
        chk("lin_stage_wrap", stage, 0);

        // Conditional jump on carry, taken then not taken.
        rom[20] = w_jmpc(1'b1, 1'b1, 40);
        start_uaddr = 9'd20; cycle_steps = 4'd3; carry = 1'b1;
        cyc(1'b0);
        stp(); stp();
        chk("jmpc_taken", rom_addr, 40);
        stp();
        carry = 1'b0;
        stp(); stp();
        chk("jmpc_fallthru", rom_addr, 21);
        stp();

        // Nested calls beyond the stack depth.
        for (int i = 0; i < 5; i++) rom[60 + i] = w_call(61 + i);
        start_uaddr = 9'd60; cycle_steps = 4'd7;
        cyc(1'b0);
        for (int i = 0; i < 7; i++) stp();
`ifdef MICROSEQ_STACK_EN
        chk("call_overflow_err", stack_err, 1);
`else
        chk("call_as_jmp_noerr", stack_err, 0);
`endif
        do_reset();

        // CALL 50 at 30, RET at 50, back to 31.
        rom[30] = w_call(50); rom[50] = w_ret(); rom[31] = w_exec(31);
        start_uaddr = 9'd30; cycle_steps = 4'd4;
        cyc(1'b0);
        stp(); chk("call_addr0", rom_addr, 30);
        stp(); chk("call_addr1", rom_addr, 50);
        stp();
`ifdef MICROSEQ_STACK_EN
        chk("ret_addr", rom_addr, 31);
        chk("ret_noerr", stack_err, 0);
`else
        chk("ret_addr_nostack", rom_addr, 51);
        chk("ret_err_nostack", stack_err, 1);
`endif
        stp();
        do_reset();

        // Interrupt raised mid-instruction, priority with and without bit 14.
        irq_enable = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            irq_mask = (pass == 0) ? 15'h7FFF : 15'h3FFF;
            start_uaddr = 9'd10; cycle_steps = 4'd5;
            stp(); stp();
            irq_req = 15'h4005;
            stp(); stp(); stp();
            chk("irq_not_yet", performing_irq, 0);
            stp();
            chk("irq_perf", performing_irq, 1);
            chk("irq_vec", irq_vector, (pass == 0) ? 14 : 2);
            chk("irq_addr", rom_addr, 400);
            irq_req = '0;
            for (int i = 0; i < 11; i++) stp();
            chk("irq_done", performing_irq, 0);
        end
        irq_mask = 15'h7FFF;

        // HALT, then wake on source 3.
        rom[80] = w_halt();
        start_uaddr = 9'd80; cycle_steps = 4'd4;
        cyc(1'b0);
        stp(); stp();
        chk("halt_set", halted, 1);
        for (int i = 0; i < 3; i++) stp();
        chk("halt_hold", halted, 1);
        irq_req = 15'h0008;
        stp();
        chk("wake_halted", halted, 0);
        chk("wake_perf", performing_irq, 1);
        chk("wake_vec", irq_vector, 3);
        irq_req = '0;
        for (int i = 0; i < 11; i++) stp();

        // HALT with interrupts disabled stays halted.
        irq_enable = 1'b0;
        stp(); stp();
        irq_req = 15'h0008;
        for (int i = 0; i < 4; i++) stp();
        chk("halt_ien0", halted, 1);
        chk("halt_ien0_perf", performing_irq, 0);
        irq_req = '0; irq_enable = 1'b1;
        do_reset();

        // Reset at stage 3 with the pending latch set.
        start_uaddr = 9'd10; cycle_steps = 4'd5;
        stp(); stp();
        irq_req = 15'h0001;
        stp();
        irq_req = '0;
        chk("pre_rst_stage", stage, 3);
        chk("pre_rst_pending", ss_ready, 0);
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b0;
        chk("rst_mid_stage", stage, 0);
        chk("rst_mid_addr", rom_addr, 0);
        chk("rst_mid_ss", ss_ready, 1);
        stp();
        chk("rst_no_irq", performing_irq, 0);
        chk("rst_decode_addr", rom_addr, 10);
        for (int i = 0; i < 4; i++) stp();

        // Randomized programs and inputs.
        for (int i = 0; i < 512; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70)      rom[i] = {3'($urandom_range(0, 2)), 13'($urandom)};
            else if (r < 78) rom[i] = w_jmp($urandom_range(0, 511));
            else if (r < 86) rom[i] = w_jmpc(1'($urandom), 1'($urandom), $urandom_range(0, 511));
            else if (r < 92) rom[i] = w_call($urandom_range(0, 511));
            else if (r < 97) rom[i] = w_ret();
            else             rom[i] = w_halt();
        end
        do_reset();
        for (int it = 0; it < 600; it++) begin
            if (m_stage == 0) begin
                cycle_steps = 4'($urandom_range(1, 12));
                start_uaddr = 9'($urandom_range(0, 511));
            end
            zero       = 1'($urandom);
            carry      = 1'($urandom);
            irq_enable = ($urandom_range(0, 9) < 8);
            irq_block  = ($urandom_range(0, 9) == 0);
            irq_mask   = 15'($urandom);
            irq_req    = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'd0;
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                cyc(1'b0);
                reset = 1'b0;
            end
            stp();
            if ($urandom_range(0, 3) == 0) cyc(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
